fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0004, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (fixed 2; other values unsupported).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_pc  output  32  byte address to instruction memory.
REQ-006 SHALL have port imem_req  output  1  read strobe to instruction memory, one read per cycle max.
REQ-007 SHALL have port imem_instruction  input  32  read data, valid exactly one cycle after a cycle with imem_req=1.
REQ-008 SHALL have port dec_valid  output  1  buffer head holds an instruction for decode.
REQ-009 SHALL have port dec_ready  input  1  decode accepts the head this cycle.
REQ-010 SHALL have port dec_instr  output  32  instruction at buffer head.
REQ-011 SHALL have port dec_pc  output  32  byte address of dec_instr.
REQ-012 SHALL have port redir_valid  input  1  branch/jump redirect request.
REQ-013 SHALL have port redir_pc  input  32  redirect target byte address.

Function
REQ-014 SHALL implement states IDLE and RUN: IDLE for exactly one cycle after reset release, then RUN permanently until reset.
REQ-015 SHALL assert imem_req in RUN only when (buffer occupancy + in-flight reads) < 2 and redir_valid=0.
REQ-016 SHALL increment the fetch PC by 4 per issued request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 SHALL write the response, tagged with its request PC, into the buffer at the end of the response cycle; dec_valid rises the following cycle.
REQ-018 SHALL complete a transfer on any cycle with dec_valid=1 and dec_ready=1, popping the head at that edge; dec_instr/dec_pc SHALL hold stable while dec_valid=1 and dec_ready=0.
REQ-019 SHALL allow push and pop in the same cycle when the buffer is full, keeping occupancy at 2 without data loss.
REQ-020 SHALL, on redir_valid=1, gate dec_valid low that cycle (redirect wins over a simultaneous handshake), clear the buffer, load the fetch PC with {redir_pc[31:2],2'b00}, and toggle a 1-bit epoch.
REQ-021 SHALL drop any response whose request epoch differs from the current epoch.
REQ-022 SHALL give redirect-to-dec_valid latency of 3 cycles (redirect cycle N, imem_req at N+1, data at N+2, dec_valid at N+3).
REQ-023 SHALL treat back-to-back redirects as last-wins; each intermediate target is discarded.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, fetch PC=RESET_PC, buffer empty, in-flight=0, epoch=0, imem_req=0, dec_valid=0, dec_instr=0, dec_pc=0, imem_pc=RESET_PC.
REQ-025 SHALL discard any read in flight when reset asserts mid-operation; first dec_valid after release at cycle 3 (cycle 0 = first edge with rst_n=1).

Configuration
REQ-026 SHALL, with FETCH_PERF_CNT_EN defined, add output perf_stall_cnt (16 bits): counts RUN cycles with dec_valid=0, saturating at 16'hFFFF, reset to 0, not cleared by redirect.
REQ-027 SHALL, without FETCH_PERF_CNT_EN, omit perf_stall_cnt and its logic entirely.

Structure
REQ-028 SHALL take ADDR_W=32, INSTR_W=32, the IDLE/RUN state enum and the PC increment constant 4 from the shared package mips_pkg.
REQ-029 SHALL place the 2-entry instruction/PC buffer in sub-module fetch_buf (push, pop, flush, full, empty, count).

Verification
REQ-030 SHALL cover reset release with dec_ready=1: imem_pc 4,8,12,... on consecutive cycles; dec_valid first at cycle 3 with dec_pc=4.
REQ-031 SHALL cover dec_ready=0 for 10 cycles: buffer fills to 2, imem_req=0, dec_pc=4 held; on release, pcs 4,8,12 delivered in order, none lost or duplicated.
REQ-032 SHALL cover redir_valid with redir_pc=32'h78 while a read is in flight: stale word dropped, next delivered dec_pc=32'h78 exactly 3 cycles later.
REQ-033 SHALL cover redirect with dec_valid=1 and dec_ready=1 in the same cycle: dec_valid low that cycle, no transfer counted.
REQ-034 SHALL cover redir_pc=32'hFFFF_FFFE: dec_pc sequence 32'hFFFF_FFFC then 32'h0000_0000.
REQ-035 SHALL cover rst_n asserted mid-stream and, with FETCH_PERF_CNT_EN, 5 stalled RUN cycles after reset: perf_stall_cnt=5.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: widths, fetch FSM state constants and PC helpers shared by the fetch slice.
package mips_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry in-order {pc, instr} buffer with push, pop, flush and occupancy flags.
module fetch_buf
  import mips_pkg::*;
#(
  parameter int W = ADDR_W + INSTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  assign head = e0;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      e0 <= '0;
      e1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      // e0 is always the head; a push lands behind whatever survives the pop
      if (pop) e0 <= (push && count == 2'd1) ? din : e1;
      else if (push && empty) e0 <= din;
      if (push && (pop ? full : count == 2'd1)) e1 <= din;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch with 2-entry buffer, epoch-tagged redirect and flush.
// Optional perf_stall_cnt output when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0004,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_pc,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cnt
`endif
);
  logic [0:0] state;
  logic [ADDR_W-1:0] fpc, inflight_pc;
  logic epoch, inflight, inflight_epoch;
  logic push, pop, full, empty;
  logic [1:0] count;
  logic [ADDR_W+INSTR_W-1:0] head;
  assign imem_pc = fpc;
  assign imem_req = state == S_RUN && !redir_valid && ({1'b0, count} + {2'b00, inflight}) < 3'(BUF_DEPTH);
  assign dec_valid = !empty && !redir_valid;
  assign dec_pc = empty ? '0 : head[ADDR_W+INSTR_W-1:INSTR_W];
  assign dec_instr = empty ? '0 : head[INSTR_W-1:0];
  assign pop = dec_valid && dec_ready;
  // a redirect flushes, so a response landing in the redirect cycle is dropped too
  assign push = inflight && inflight_epoch == epoch && !redir_valid && (!full || pop);
  fetch_buf u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din({inflight_pc, imem_instruction}),
    .pop(pop),
    .flush(redir_valid),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      fpc <= RESET_PC;
      epoch <= 1'b0;
      inflight <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state <= S_RUN;
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fpc;
        inflight_epoch <= epoch;
      end
      if (redir_valid) begin
        fpc <= align_pc(redir_pc);
        epoch <= ~epoch;
      end else if (imem_req) begin
        fpc <= fpc + PC_INC;
      end
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_stall_cnt <= '0;
    else if (state == S_RUN && !dec_valid && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed corner sequences and random traffic checked against a queue model.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0004;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_pc, imem_instruction = '0, dec_instr, dec_pc, redir_pc = '0;
  logic imem_req, dec_valid, dec_ready = 1'b0, redir_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_pc(imem_pc),
    .imem_req(imem_req),
    .imem_instruction(imem_instruction),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction
  bit m_run, m_ep, m_inf, m_inf_ep, p_req;
  logic [31:0] m_fpc, m_inf_pc, p_pc;
  logic [31:0] m_q[$];
  logic [31:0] acc_q[$];
  int m_perf;
  logic s_req, s_dv;
  logic [31:0] s_ipc, s_dpc;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rp);
    bit e_req, e_dv;
    logic [31:0] e_ipc, e_dpc, e_ins;
    @(negedge clk);
    rst_n = r;
    dec_ready = rdy;
    redir_valid = rv;
    redir_pc = rp;
    imem_instruction = p_req ? mem(p_pc) : $urandom;
    #1;
    if (!r) begin
      m_run = 0; m_fpc = RST_PC; m_ep = 0; m_inf = 0; m_perf = 0;
      m_q.delete();
    end
    e_req = r && m_run && !rv && (m_q.size() + int'(m_inf)) < 2;
    e_dv = r && !rv && m_q.size() > 0;
    e_ipc = m_fpc;
    e_dpc = m_q.size() > 0 ? m_q[0] : 32'h0;
    e_ins = m_q.size() > 0 ? mem(m_q[0]) : 32'h0;
    check("imem_req", imem_req, e_req);
    check("imem_pc", imem_pc, e_ipc);
    check("dec_valid", dec_valid, e_dv);
    check("dec_pc", dec_pc, e_dpc);
    check("dec_instr", dec_instr, e_ins);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'(m_perf));
`endif
    s_req = imem_req; s_ipc = imem_pc; s_dv = dec_valid; s_dpc = dec_pc;
    if (dec_valid && rdy) acc_q.push_back(dec_pc);
    p_req = imem_req;
    p_pc = imem_pc;
    if (r) begin
      if (m_run && !e_dv && m_perf < 65535) m_perf++;
      if (rv) begin
        m_q.delete();
        m_ep = ~m_ep;
        m_fpc = rp & ~32'd3;
      end else begin
        if (e_dv && rdy) void'(m_q.pop_front());
        if (m_inf && m_inf_ep == m_ep) m_q.push_back(m_inf_pc);
        if (e_req) m_fpc = m_fpc + 32'd4;
      end
      m_inf = e_req;
      m_inf_pc = e_ipc;
      m_inf_ep = m_ep;
      m_run = 1;
    end
  endtask
  typedef struct {
    bit rdy;
    bit req;
    logic [31:0] ipc;
    bit dv;
    logic [31:0] dpc;
  } vec_t;
  vec_t tbl[8];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int first;
    int n;
    logic [31:0] first_pc;
    tbl[0] = '{1'b1, 1'b0, 32'd4, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 32'd4, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 32'd8, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd4};
    tbl[4] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[5] = '{1'b1, 1'b1, 32'd16, 1'b0, 32'd0};
    tbl[6] = '{1'b1, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[7] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
    p_req = 0;
    repeat (3) step(0, 1, 0, 0);
    check("reset_dv", s_dv, 0);
    check("reset_ipc", s_ipc, RST_PC);
    for (int i = 0; i < 8; i++) begin
      step(1, tbl[i].rdy, 0, 0);
      check("tbl_req", s_req, tbl[i].req);
      check("tbl_ipc", s_ipc, tbl[i].ipc);
      check("tbl_dv", s_dv, tbl[i].dv);
      check("tbl_dpc", s_dpc, tbl[i].dpc);
    end
    // backpressure: buffer fills and fetch stops, then drains in order
    step(0, 0, 0, 0);
    repeat (10) step(1, 0, 0, 0);
    check("bp_dv", s_dv, 1);
    check("bp_dpc", s_dpc, 32'd4);
    check("bp_req", s_req, 0);
    acc_q.delete();
    repeat (6) step(1, 1, 0, 0);
    check("bp_cnt", 32'(acc_q.size() >= 3), 1);
    if (acc_q.size() >= 3) begin
      check("bp_order0", acc_q[0], 32'd4);
      check("bp_order1", acc_q[1], 32'd8);
      check("bp_order2", acc_q[2], 32'd12);
    end
    // redirect while a read is in flight
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      step(1, 1, 0, 0);
      if (s_req) first = i;
    end
    check("inflight_found", 32'(first >= 0), 1);
    step(1, 1, 1, 32'h78);
    check("rd_n_dv", s_dv, 0);
    step(1, 1, 0, 0);
    check("rd_n1_req", s_req, 1);
    check("rd_n1_ipc", s_ipc, 32'h78);
    step(1, 1, 0, 0);
    check("rd_n2_dv", s_dv, 0);
    step(1, 1, 0, 0);
    check("rd_n3_dv", s_dv, 1);
    check("rd_n3_dpc", s_dpc, 32'h78);
    // redirect beats a simultaneous handshake
    repeat (6) step(1, 0, 0, 0);
    check("hs_pre_dv", s_dv, 1);
    n = acc_q.size();
    step(1, 1, 1, 32'h200);
    check("hs_dv", s_dv, 0);
    check("hs_no_xfer", 32'(acc_q.size()), 32'(n));
    repeat (3) step(1, 1, 0, 0);
    check("hs_dpc", s_dpc, 32'h200);
    // PC wrap
    acc_q.delete();
    step(1, 1, 1, 32'hFFFF_FFFE);
    repeat (8) step(1, 1, 0, 0);
    check("wrap_cnt", 32'(acc_q.size() >= 2), 1);
    if (acc_q.size() >= 2) begin
      check("wrap0", acc_q[0], 32'hFFFF_FFFC);
      check("wrap1", acc_q[1], 32'h0);
    end
    // reset mid-stream: first dec_valid at cycle 3 with pc RESET_PC
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("mid_rst_dv", s_dv, 0);
    check("mid_rst_req", s_req, 0);
    first = -1;
    first_pc = '0;
    for (int c = 0; c < 8; c++) begin
      step(1, 1, 0, 0);
      if (s_dv && first < 0) begin
        first = c;
        first_pc = s_dpc;
      end
    end
    check("first_dv_cycle", 32'(first), 32'd3);
    check("first_dv_pc", first_pc, RST_PC);
`ifdef FETCH_PERF_CNT_EN
    step(0, 1, 0, 0);
    repeat (6) step(1, 1, 1, 32'h4);
    step(1, 1, 0, 0);
    check("perf_5", 32'(perf_stall_cnt), 32'd5);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(11) == 0, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
